// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial evaluator: FSM states, ALU ops and
// register-select codes used by both the sequencer and the datapath.
package poly_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C0   = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    C3   = 3'd4,
    C4   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

endpackage

// File: rtl/poly_eval_datapath.sv
// Four operand registers, two 4:1 operand muxes, a shared add/mul ALU and the
// result register. All arithmetic wraps modulo 2^WIDTH.
module poly_eval_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_a,
  input  logic [WIDTH-1:0] cap_b,
  input  logic [WIDTH-1:0] cap_c,
  input  logic [WIDTH-1:0] cap_x,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_res,
  input  logic [1:0]       sel_a,
  input  logic [1:0]       sel_b,
  input  logic             op,
  output logic [WIDTH-1:0] result
);
  import poly_pkg::*;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d, res_q, res_d;
  logic [WIDTH-1:0] opa, opb, alu;

  // Operands and result share WIDTH, so the expression context drops the carry
  // and high product bits: plain modulo arithmetic, no saturation.
  function automatic logic [WIDTH-1:0] mul_wrap(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q);
    return p * q;
  endfunction

  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q);
    return p + q;
  endfunction

  always_comb begin
    case (sel_a)
      SEL_A:   opa = a_q;
      SEL_B:   opa = b_q;
      SEL_C:   opa = c_q;
      default: opa = x_q;
    endcase
    case (sel_b)
      SEL_A:   opb = a_q;
      SEL_B:   opb = b_q;
      SEL_C:   opb = c_q;
      default: opb = x_q;
    endcase
    alu = (op == OP_MUL) ? mul_wrap(opa, opb) : add_wrap(opa, opb);

    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    x_d   = x_q;
    res_d = res_q;
    if (capture) begin
      a_d = cap_a;
      b_d = cap_b;
      c_d = cap_c;
      x_d = cap_x;
    end else begin
      if (ld_a)   a_d   = alu;
      if (ld_b)   b_d   = alu;
      if (ld_res) res_d = alu;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      x_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      x_q   <= x_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/poly_eval_arbiter.sv
// Two-requester front end for the shared evaluator: round-robin grant, operand
// capture and the five-step sequence computing y = A*X^2 + B*X + C.
module poly_eval_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] x1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  import poly_pkg::*;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   winner, capture, ld_a, ld_b, ld_res, op;
  logic [1:0] sel_a, sel_b;
  logic [WIDTH-1:0] cap_a, cap_b, cap_c, cap_x;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt     = 2'b00;
    done    = 2'b00;
    capture = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_res  = 1'b0;
    sel_a   = SEL_A;
    sel_b   = SEL_X;
    op      = OP_ADD;
    // Requester 1 wins alone, or on a tie when requester 0 was served last.
    winner  = req[1] & (~req[0] | ~last_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt     = winner ? 2'b10 : 2'b01;
          capture = 1'b1;
          owner_d = winner;
          last_d  = winner;
          state_d = C0;
        end
      end
      C0: begin
        op = OP_MUL; sel_a = SEL_A; sel_b = SEL_X; ld_a = 1'b1; state_d = C1;
      end
      C1: begin
        op = OP_MUL; sel_a = SEL_B; sel_b = SEL_X; ld_b = 1'b1; state_d = C2;
      end
      C2: begin
        op = OP_MUL; sel_a = SEL_A; sel_b = SEL_X; ld_a = 1'b1; state_d = C3;
      end
      C3: begin
        op = OP_ADD; sel_a = SEL_A; sel_b = SEL_B; ld_a = 1'b1; state_d = C4;
      end
      C4: begin
        op = OP_ADD; sel_a = SEL_A; sel_b = SEL_C; ld_res = 1'b1; state_d = DONE;
      end
      DONE: begin
        done    = owner_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    cap_a = winner ? a1 : a0;
    cap_b = winner ? b1 : b0;
    cap_c = winner ? c1 : c0;
    cap_x = winner ? x1 : x0;
  end

  assign busy = (state_q != IDLE);

  poly_eval_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .resetn  (resetn),
    .capture (capture),
    .cap_a   (cap_a),
    .cap_b   (cap_b),
    .cap_c   (cap_c),
    .cap_x   (cap_x),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .ld_res  (ld_res),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .op      (op),
    .result  (result)
  );

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_poly_eval_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [7:0] a0, b0, c0, x0, a1, b1, c1, x1;
  logic [1:0] gnt, done;
  logic [7:0] result;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  poly_eval_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .a0(a0), .b0(b0), .c0(c0), .x0(x0),
    .a1(a1), .b1(b1), .c1(c1), .x1(x1),
    .gnt(gnt), .done(done), .result(result), .busy(busy)
  );

  task automatic test_reset;
    resetn = 1'b0; req = 2'b00;
    {a0, b0, c0, x0, a1, b1, c1, x1} = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b want=00", gnt); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL rst_done got=%b want=00", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL rst_result got=%h want=00", result); end
  endtask

  task automatic test_single;
    logic [1:0] exp_d;
    @(negedge clk);
    resetn = 1'b1;
    a0 = 8'd2; b0 = 8'd3; c0 = 8'd4; x0 = 8'd5; req = 2'b01;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b want=01", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_T got=%b want=0", busy); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      #1;
      exp_d = (k == 6) ? 2'b01 : 2'b00;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy k=%0d got=%b want=1", k, busy); end
      checks++; if (done !== exp_d) begin failures++; $display("FAIL single_done k=%0d got=%b want=%b", k, done, exp_d); end
      if (k == 6) begin
        checks++; if (result !== 8'h45) begin failures++; $display("FAIL single_result got=%h want=45", result); end
      end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    checks++; if (result !== 8'h45) begin failures++; $display("FAIL single_hold got=%h want=45", result); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g, exp_d;
    logic [7:0] exp_r;
    @(negedge clk);
    resetn = 1'b0; req = 2'b11;
    a0 = 8'd1; b0 = 8'd1; c0 = 8'd1; x0 = 8'd1;
    a1 = 8'd0; b1 = 8'd0; c1 = 8'd7; x1 = 8'd9;
    @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_g = j[0] ? 2'b10 : 2'b01;
      exp_r = j[0] ? 8'd7 : 8'd3;
      if (j > 0) @(negedge clk);
      #1;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt j=%0d got=%b want=%b", j, gnt, exp_g); end
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (j == 2 && k == 1) req = 2'b00;
        #1;
        exp_d = (k == 6) ? exp_g : 2'b00;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rr_gnt_busy j=%0d k=%0d got=%b want=00", j, k, gnt); end
        checks++; if (done !== exp_d) begin failures++; $display("FAIL rr_done j=%0d k=%0d got=%b want=%b", j, k, done, exp_d); end
        if (k == 6) begin
          checks++; if (result !== exp_r) begin failures++; $display("FAIL rr_result j=%0d got=%h want=%h", j, result, exp_r); end
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic [1:0] exp_d;
    @(negedge clk);
    a1 = 8'd16; b1 = 8'd0; c1 = 8'd1; x1 = 8'd4; req = 2'b10;
    #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL ovf_gnt got=%b want=10", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      #1;
      exp_d = (k == 6) ? 2'b10 : 2'b00;
      checks++; if (done !== exp_d) begin failures++; $display("FAIL ovf_done k=%0d got=%b want=%b", k, done, exp_d); end
      if (k == 6) begin
        checks++; if (result !== 8'h01) begin failures++; $display("FAIL ovf_result got=%h want=01", result); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_d;
    @(negedge clk);
    a0 = 8'd2; b0 = 8'd3; c0 = 8'd4; x0 = 8'd5; req = 2'b01;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL b2b_gnt0 got=%b want=01", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      if (k == 3) begin
        a1 = 8'd1; b1 = 8'd2; c1 = 8'd3; x1 = 8'd4; req = 2'b10;
      end
      #1;
      exp_d = (k == 6) ? 2'b01 : 2'b00;
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL b2b_gnt_busy k=%0d got=%b want=00", k, gnt); end
      checks++; if (done !== exp_d) begin failures++; $display("FAIL b2b_done0 k=%0d got=%b want=%b", k, done, exp_d); end
      if (k == 6) begin
        checks++; if (result !== 8'd69) begin failures++; $display("FAIL b2b_result0 got=%h want=45", result); end
      end
    end
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL b2b_gnt1 got=%b want=10", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      #1;
      exp_d = (k == 6) ? 2'b10 : 2'b00;
      checks++; if (done !== exp_d) begin failures++; $display("FAIL b2b_done1 k=%0d got=%b want=%b", k, done, exp_d); end
      if (k == 6) begin
        checks++; if (result !== 8'd27) begin failures++; $display("FAIL b2b_result1 got=%h want=1b", result); end
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [1:0] exp_d;
    int done_seen;
    @(negedge clk);
    a0 = 8'd2; b0 = 8'd3; c0 = 8'd4; x0 = 8'd5; req = 2'b01;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_gnt got=%b want=01", gnt); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      if (k == 4) resetn = 1'b0;
      #1;
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL abort_result got=%h want=00", result); end
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done !== 2'b00) done_seen++;
      @(negedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", done_seen); end
    req = 2'b11;
    a1 = 8'd9; b1 = 8'd9; c1 = 8'd9; x1 = 8'd9;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_regrant got=%b want=01", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 2'b00;
      #1;
      exp_d = (k == 6) ? 2'b01 : 2'b00;
      checks++; if (done !== exp_d) begin failures++; $display("FAIL abort_done k=%0d got=%b want=%b", k, done, exp_d); end
      if (k == 6) begin
        checks++; if (result !== 8'd69) begin failures++; $display("FAIL abort_result2 got=%h want=45", result); end
      end
    end
  endtask

  task automatic test_boundaries;
    logic [1:0] exp_g, exp_d;
    logic [7:0] exp_r;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        a0 = 8'hFF; b0 = 8'hFF; c0 = 8'h80; x0 = 8'h00; req = 2'b01;
        exp_g = 2'b01; exp_r = 8'h80;
      end else begin
        a1 = 8'h00; b1 = 8'h01; c1 = 8'h01; x1 = 8'hFF; req = 2'b10;
        exp_g = 2'b10; exp_r = 8'h00;
      end
      #1;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL bnd_gnt j=%0d got=%b want=%b", j, gnt, exp_g); end
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) req = 2'b00;
        #1;
        exp_d = (k == 6) ? exp_g : 2'b00;
        checks++; if (done !== exp_d) begin failures++; $display("FAIL bnd_done j=%0d k=%0d got=%b want=%b", j, k, done, exp_d); end
        if (k == 6) begin
          checks++; if (result !== exp_r) begin failures++; $display("FAIL bnd_result j=%0d got=%h want=%h", j, result, exp_r); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_boundaries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_eval_arbiter.md
Name: poly_eval_arbiter

Overview:
- Shares one 4-register/one-ALU polynomial datapath between two requesters.
- Each requester supplies A, B, C and X; the block returns y = A*X^2 + B*X + C.
- It replaces the push-button load sequence with a req/gnt/done handshake, so other logic can use the evaluator without a human in the loop.
- The block contains round-robin arbitration, the sequencing FSM that drives the datapath load and select controls, and per-requester result delivery.

Parameters:
WIDTH, 8, width of coefficients, X and result; all arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  synchronous active-low reset.
req  input  2  req[i] high requests an evaluation; held until gnt[i].
a0, b0, c0, x0  input  WIDTH each  requester 0 operands; stable while req[0] is high.
a1, b1, c1, x1  input  WIDTH each  requester 1 operands; stable while req[1] is high.
gnt  output  2  one-hot, one-cycle pulse; operands of the winner are captured this cycle.
done  output  2  one-hot, one-cycle pulse to the owner when the result is valid.
result  output  WIDTH  last computed y; holds until the next done.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (resetn low at a clk edge):
  - state = IDLE; gnt = 0; done = 0; busy = 0; result = 0.
  - Internal a, b, c, x registers = 0; owner = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- Reset mid-operation aborts the evaluation: no done is issued and result is cleared to 0.
- FSM states: IDLE, C0, C1, C2, C3, C4, DONE.
- IDLE:
  - If any req is high, pick a winner. A single requester wins outright. If both are high, the winner is ~last.
  - In the same cycle: gnt[winner] = 1 (combinational from IDLE and req); capture the winner's operands into a/b/c/x; owner <= winner; last <= winner; next state C0.
  - If no req is high, stay in IDLE.
- Datapath steps (C0-C3 write back into the named register; no write in C4):
  - C0: a <= a*x
  - C1: b <= b*x
  - C2: a <= a*x
  - C3: a <= a + b
  - C4: result <= a + c
- DONE: done[owner] = 1 for exactly one cycle; result is valid this cycle; next state IDLE.
- Latency: gnt at cycle T, done at T+6. Back-to-back throughput is one evaluation per 7 cycles.
- Requests arriving while busy are not granted. req stays pending and is arbitrated on the next IDLE cycle. The cycle after DONE can grant immediately.
- Fairness: with both req held continuously, grants alternate 0,1,0,1,...
- A requester dropping req before gnt withdraws its request; no error is raised.
- Products and sums truncate to the low WIDTH bits, with no saturation and no overflow flag.
- gnt and done are never both high in the same cycle. Each is at most one-hot.

Decomposition:
- Shared package poly_pkg holds:
  - State encoding localparams: IDLE=0, C0..C4=1..5, DONE=6.
  - ALU op constants: OP_ADD=0, OP_MUL=1.
  - Register select codes: SEL_A=0, SEL_B=1, SEL_C=2, SEL_X=3.
- One sub-module, poly_eval_datapath:
  - Contains the a/b/c/x registers, the two 4:1 operand muxes, the add/mul ALU and the result register.
  - Controlled by ld_* enables, a capture strobe, sel_a, sel_b and op.
  - The top level holds the FSM, the arbiter and the operand-capture mux.

Test Plan:
1. Reset, then req=01 with a0=2, b0=3, c0=4, x0=5 → gnt=01 at T; busy is high T+1..T+6; done=01 at T+6; result=0x45 (69).
2. req=11 held from reset; r0 = (1,1,1,1) and r1 = (0,0,7,9) → gnt=01 first (result 3, done=01), then gnt=10 (result 7, done=10), then gnt=01 again.
3. Overflow: a1=16, b1=0, c1=1, x1=4 → result 0x01 (257 mod 256), done=10.
4. req[1] raised at C2 of a requester-0 job → not granted until the IDLE after DONE. Its gnt arrives exactly 1 cycle after done[0]. No gnt pulses occur while busy.
5. resetn low for one cycle at C3 → next cycle state is IDLE, result=0, no done pulse. A new req is granted normally afterwards.
6. x=0, a=b=0xFF, c=0x80 → result 0x80. x=0xFF, a=0, b=1, c=1 → result 0x00 (wrap).
